// File: rtl/psddivide_param.sv
// Sequential non-restoring divider, WIDTH bits, signed/unsigned per operation.
// One quotient bit per cycle; start-to-done latency is WIDTH+1 clock edges.
module psddivide_param #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] rest,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX
  } state_e;

  state_e state_q, state_d;

  logic             smode_q, smode_d;
  logic             dsgn_q, dsgn_d;
  logic             vsgn_q, vsgn_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rst_q, rst_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;

  logic             dsgn_in, vsgn_in;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh, rem_nx;
  logic [WIDTH-1:0] r_mag, q_res, r_res;
  logic             dz_now;

  assign dsgn_in = signed_mode & dividend[WIDTH-1];
  assign vsgn_in = signed_mode & divisor[WIDTH-1];
  assign a_mag   = dsgn_in ? {WIDTH{1'b0}} - dividend : dividend;
  assign b_mag   = vsgn_in ? {WIDTH{1'b0}} - divisor : divisor;

  // Remainder keeps a sign bit; dividend bits shift in from acc_q.
  assign rem_sh = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
  assign rem_nx = rem_q[WIDTH] ? rem_sh + {1'b0, dvs_q}
                               : rem_sh - {1'b0, dvs_q};

  assign r_mag  = rem_q[WIDTH] ? rem_q[WIDTH-1:0] + dvs_q
                               : rem_q[WIDTH-1:0];
  assign dz_now = (dvs_q == '0);

  // A zero divisor leaves the dividend in the remainder, so only q is forced.
  always_comb begin
    q_res = acc_q;
    r_res = r_mag;
    if (smode_q && (dsgn_q ^ vsgn_q)) q_res = {WIDTH{1'b0}} - acc_q;
    if (smode_q && dsgn_q)            r_res = {WIDTH{1'b0}} - r_mag;
    if (dz_now)                       q_res = '1;
  end

  always_comb begin
    state_d = state_q;
    smode_d = smode_q;
    dsgn_d  = dsgn_q;
    vsgn_d  = vsgn_q;
    dvs_d   = dvs_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rst_d   = rst_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          smode_d = signed_mode;
          dsgn_d  = dividend[WIDTH-1];
          vsgn_d  = divisor[WIDTH-1];
          acc_d   = a_mag;
          dvs_d   = b_mag;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        rem_d = rem_nx;
        acc_d = {acc_q[WIDTH-2:0], ~rem_nx[WIDTH]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        quo_d   = q_res;
        rst_d   = r_res;
        dz_d    = dz_now;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      smode_q <= 1'b0;
      dsgn_q  <= 1'b0;
      vsgn_q  <= 1'b0;
      dvs_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rst_q   <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      smode_q <= smode_d;
      dsgn_q  <= dsgn_d;
      vsgn_q  <= vsgn_d;
      dvs_q   <= dvs_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rst_q   <= rst_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quo_q;
  assign rest        = rst_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_psddivide_param.sv
// Directed-vector bench for psddivide_param (WIDTH=32 and WIDTH=8).
// Checks results, latency, handshake and mid-operation reset.
module tb_psddivide_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        st32, sm32;
  logic [31:0] dd32, dv32;
  logic        busy32, done32, dz32;
  logic [31:0] q32, r32;

  logic        st8, sm8;
  logic [7:0]  dd8, dv8;
  logic        busy8, done8, dz8;
  logic [7:0]  q8, r8;

  psddivide_param #(.WIDTH(32)) dut32 (
    .clock(clk), .reset(rst_n), .start(st32),
    .signed_mode(sm32), .dividend(dd32),
    .divisor(dv32), .busy(busy32), .done(done32),
    .quotient(q32), .rest(r32), .div_by_zero(dz32)
  );

  psddivide_param #(.WIDTH(8)) dut8 (
    .clock(clk), .reset(rst_n), .start(st8),
    .signed_mode(sm8), .dividend(dd8),
    .divisor(dv8), .busy(busy8), .done(done8),
    .quotient(q8), .rest(r8), .div_by_zero(dz8)
  );

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  // Launch at the next edge, then count edges until done is seen.
  task automatic run32(input logic s, input logic [31:0] a,
                       input logic [31:0] b, output int lat);
    st32 = 1'b1; sm32 = s; dd32 = a; dv32 = b;
    @(posedge clk); #1;
    st32 = 1'b0; dd32 = ~a; dv32 = ~b; sm32 = ~s;
    lat = 0;
    while (!done32 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run8(input logic s, input logic [7:0] a,
                      input logic [7:0] b, output int lat);
    st8 = 1'b1; sm8 = s; dd8 = a; dv8 = b;
    @(posedge clk); #1;
    st8 = 1'b0; dd8 = ~a; dv8 = ~b; sm8 = ~s;
    lat = 0;
    while (!done8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  function automatic void ref32(input logic s, input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] q,
                                output logic [31:0] r);
    longint x, y;
    x = s ? longint'($signed(a)) : longint'({32'd0, a});
    y = s ? longint'($signed(b)) : longint'({32'd0, b});
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else begin
      q = 32'(x / y); r = 32'(x % y);
    end
  endfunction

  function automatic void ref8(input logic s, input logic [7:0] a,
                               input logic [7:0] b,
                               output logic [7:0] q,
                               output logic [7:0] r);
    int x, y;
    x = s ? int'($signed(a)) : int'({24'd0, a});
    y = s ? int'($signed(b)) : int'({24'd0, b});
    if (b == 8'd0) begin
      q = 8'hFF; r = a;
    end else if (s && a == 8'h80 && b == 8'hFF) begin
      q = 8'h80; r = 8'd0;
    end else begin
      q = 8'(x / y); r = 8'(x % y);
    end
  endfunction

  vec_t vt[12];
  int lat;
  logic [31:0] eq, er, ra, rb;
  logic [7:0] eq8, er8, a8, b8;
  logic rs;
  int ndone;

  initial begin
    vt[0]  = '{1'b0, 32'h12345678, 32'h0BEEFEBA, 32'h1, 32'h064557BE, 1'b0};
    vt[1]  = '{1'b0, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b0};
    vt[2]  = '{1'b0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b1};
    vt[3]  = '{1'b1, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    vt[4]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0};
    vt[5]  = '{1'b0, 32'h1, 32'h0, 32'hFFFFFFFF, 32'h1, 1'b1};
    vt[6]  = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
    vt[7]  = '{1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0};
    vt[8]  = '{1'b1, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1};
    vt[9]  = '{1'b1, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'd2, 32'hFFFFFFFE, 1'b0};
    vt[10] = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0};
    vt[11] = '{1'b0, 32'd5, 32'd10, 32'd0, 32'd5, 1'b0};

    rst_n = 1'b0;
    st32 = 0; sm32 = 0; dd32 = 0; dv32 = 0;
    st8 = 0; sm8 = 0; dd8 = 0; dv8 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy32}, 32'd0);
    chk("rst_done", {31'd0, done32}, 32'd0);
    chk("rst_q", q32, 32'd0);
    chk("rst_r", r32, 32'd0);
    chk("rst_dz", {31'd0, dz32}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back: each run restarts while the previous done is high.
    for (int i = 0; i < 12; i++) begin
      run32(vt[i].s, vt[i].a, vt[i].b, lat);
      chk($sformatf("v%0d_lat", i), lat, 33);
      chk($sformatf("v%0d_q", i), q32, vt[i].q);
      chk($sformatf("v%0d_r", i), r32, vt[i].r);
      chk($sformatf("v%0d_dz", i), {31'd0, dz32}, {31'd0, vt[i].dz});
      chk($sformatf("v%0d_busy", i), {31'd0, busy32}, 32'd0);
    end
    @(posedge clk); #1;
    chk("done_pulse", {31'd0, done32}, 32'd0);
    chk("hold_q", q32, 32'd0);

    // Start while busy must be ignored.
    st32 = 1'b1; sm32 = 1'b0; dd32 = 32'd1000; dv32 = 32'd7;
    @(posedge clk); #1;
    st32 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("hs_busy", {31'd0, busy32}, 32'd1);
    st32 = 1'b1; dd32 = 32'd50; dv32 = 32'd3;
    @(posedge clk); #1;
    st32 = 1'b0;
    lat = 5;
    while (!done32 && lat < 45) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hs_lat", lat, 33);
    chk("hs_q", q32, 32'd142);
    chk("hs_r", r32, 32'd6);
    @(posedge clk); #1;

    // Reset in the middle of a division.
    st32 = 1'b1; sm32 = 1'b0; dd32 = 32'hFFFF; dv32 = 32'h10;
    @(posedge clk); #1;
    st32 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", {31'd0, busy32}, 32'd0);
    chk("ar_done", {31'd0, done32}, 32'd0);
    chk("ar_q", q32, 32'd0);
    chk("ar_r", r32, 32'd0);
    chk("ar_dz", {31'd0, dz32}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32) ndone++;
    end
    chk("ar_nodone", ndone, 0);

    // Narrow instance.
    run8(1'b0, 8'd200, 8'd7, lat);
    chk("w8_lat", lat, 9);
    chk("w8_q", {24'd0, q8}, 32'd28);
    chk("w8_r", {24'd0, r8}, 32'd4);
    run8(1'b1, 8'h80, 8'hFF, lat);
    chk("w8_ovf_q", {24'd0, q8}, 32'h80);
    chk("w8_ovf_r", {24'd0, r8}, 32'h0);
    run8(1'b1, 8'hF3, 8'd0, lat);
    chk("w8_dz_q", {24'd0, q8}, 32'hFF);
    chk("w8_dz_r", {24'd0, r8}, 32'hF3);
    chk("w8_dz", {31'd0, dz8}, 32'd1);

    for (int i = 0; i < 600; i++) begin
      rs = 1'($urandom_range(0, 1));
      a8 = 8'($urandom);
      b8 = (i % 16 == 0) ? 8'd0 : 8'($urandom);
      ref8(rs, a8, b8, eq8, er8);
      run8(rs, a8, b8, lat);
      chk($sformatf("r8_%0d_q", i), {24'd0, q8}, {24'd0, eq8});
      chk($sformatf("r8_%0d_r", i), {24'd0, r8}, {24'd0, er8});
    end

    for (int i = 0; i < 250; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = (i % 4 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      if (i % 25 == 0) rb = 32'd0;
      ref32(rs, ra, rb, eq, er);
      run32(rs, ra, rb, lat);
      chk($sformatf("r32_%0d_q", i), q32, eq);
      chk($sformatf("r32_%0d_r", i), r32, er);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
